bus_master_ctrl: RTL

BUS_MASTER_CTRL -- requirements
Module: bus_master_ctrl

---
 rtl/bus_master_pkg.sv | 15 +
 rtl/bus_req_fifo.sv | 54 +++++
 rtl/bus_master_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/bus_master_pkg.sv
// Shared definitions for the bus master controller slice.
//   DEF_ADDR_W / DEF_DATA_W : default bus address / data widths
//   state_t                 : controller FSM state encoding
package bus_master_pkg;

    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/bus_req_fifo.sv
// Request buffer for bus_master_ctrl: a small synchronous FIFO with
// show-ahead read (dout always presents the oldest entry).
//   clk, rst_n : clock, asynchronous active-low reset (flushes contents)
//   push, din  : write strobe and data (caller must not push when full)
//   pop, dout  : read strobe and head-of-queue data
//   full/empty : occupancy flags
module bus_req_fifo #(
    parameter int unsigned WIDTH = 17,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // Depth is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/bus_master_ctrl.sv
// Bus master controller: buffers read/write requests and plays them out
// one at a time on a simple ce/rd/wr strobe bus, returning one response
// per transfer through a valid/ready handshake.
//   req_*      : request channel (valid/ready, wr flag, address, write data)
//   resp_*     : response channel (valid/ready, wr flag, read data)
//   ce/rd/wr   : registered bus strobes; addr/data_wr registered bus drive
//   data_rd    : read data returned by the slave
//   busy       : controller active or requests still buffered
module bus_master_ctrl
    import bus_master_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter int unsigned FIFO_DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_wr,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              ce,
    output logic              rd,
    output logic              wr,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_wr,
    input  logic [DATA_W-1:0] data_rd,
    output logic              busy
);

    localparam int unsigned PKT_W     = 1 + ADDR_W + DATA_W;
    localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYCLES);

    state_t            state;
    logic [3:0]        wait_cnt;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [PKT_W-1:0]  fifo_din;
    logic [PKT_W-1:0]  fifo_dout;
    logic              head_wr;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_wdata;

    assign req_ready = !fifo_full;
    assign push      = req_valid && !fifo_full;
    assign fifo_din  = {req_wr, req_addr, req_wdata};
    assign {head_wr, head_addr, head_wdata} = fifo_dout;

    // A new access launches from IDLE, or straight out of RESP on the
    // edge that retires the previous response.
    assign pop  = !fifo_empty &&
                  ((state == ST_IDLE) || ((state == ST_RESP) && resp_ready));
    assign busy = (state != ST_IDLE) || !fifo_empty;

    bus_req_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            ce         <= 1'b0;
            rd         <= 1'b0;
            wr         <= 1'b0;
            addr       <= '0;
            data_wr    <= '0;
            resp_valid <= 1'b0;
            resp_wr    <= 1'b0;
            resp_rdata <= '0;
        end else begin
            case (state)
                ST_IDLE: ;
                ST_ACCESS: begin
                    if (wait_cnt == WAIT_LAST) begin
                        resp_rdata <= wr ? '0 : data_rd;
                        resp_wr    <= wr;
                        resp_valid <= 1'b1;
                        ce         <= 1'b0;
                        rd         <= 1'b0;
                        wr         <= 1'b0;
                        addr       <= '0;
                        state      <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Launch is shared by IDLE and RESP; placed last so it overrides
            // the RESP->IDLE transition when another request is waiting.
            if (pop) begin
                state    <= ST_ACCESS;
                wait_cnt <= '0;
                ce       <= 1'b1;
                rd       <= !head_wr;
                wr       <= head_wr;
                addr     <= head_addr;
                if (head_wr) data_wr <= head_wdata;
            end
        end
    end

endmodule
